sq_demod_acc: RTL

- Square-wave (sign-reference) demodulator and boxcar integrator.
- Sits directly downstream of the sign extractor. Its ±1 2-bit reference multiplies the R-bit input signal, and the products are accumulated over 2^N_LOG2 accepted samples.
- Emits one averaged, saturated R-bit result per window with a one-cycle valid strobe.
- Feeds the lock-in output mux and the DAC/readout registers.

---
 rtl/lockin_pkg.sv | 23 ++
 rtl/sq_demod_mul.sv | 25 ++
 rtl/sq_demod_acc.sv | 71 +++++++
 3 files changed

// File: rtl/lockin_pkg.sv
// rtl/lockin_pkg.sv - shared lock-in reference codes and saturation helper
package lockin_pkg;

  localparam logic [1:0] REF_POS  = 2'b01;
  localparam logic [1:0] REF_NEG  = 2'b11;
  localparam logic [1:0] REF_GATE = 2'b00;

  // Clamp a wide signed value to the signed range of 'width' bits (width <= 63).
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                      input int unsigned width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v)
      return max_v;
    else if (value < min_v)
      return min_v;
    else
      return value;
  endfunction

endpackage

// File: rtl/sq_demod_mul.sv
// rtl/sq_demod_mul.sv - reference-controlled negate/gate of the input sample
// Product is one bit wider than the input so negating the most negative code cannot wrap.
module sq_demod_mul
  import lockin_pkg::*;
#(
  parameter int R = 14
) (
  input  logic signed [R-1:0] in,
  input  logic        [1:0]   ref2,
  output logic signed [R:0]   p
);

  logic signed [R:0] in_ext;

  assign in_ext = {in[R-1], in};

  always_comb begin
    p = '0;
    if (ref2 == REF_POS)
      p = in_ext;
    else if (ref2[1])
      p = -in_ext;  // 2'b10 is treated the same as REF_NEG
  end

endmodule

// File: rtl/sq_demod_acc.sv
// rtl/sq_demod_acc.sv - square-wave demodulator with boxcar average over 2^N_LOG2 samples
// Optional macro SQ_DEMOD_ROUND_EN selects round-half-up instead of floor before saturation.
module sq_demod_acc
  import lockin_pkg::*;
#(
  parameter int R      = 14,
  parameter int N_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [R-1:0] in,
  input  logic        [1:0]   ref2,
  input  logic                in_valid,
  input  logic                clear,
  output logic signed [R-1:0] out,
  output logic                out_valid,
  output logic [N_LOG2-1:0]   cnt
);

  localparam int AW = R + N_LOG2 + 1;
  localparam logic [N_LOG2-1:0] CNT_LAST = '1;

  logic signed [R:0]    p;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] rnd;
  logic signed [AW-1:0] shifted;

  sq_demod_mul #(.R(R)) u_mul (
    .in   (in),
    .ref2 (ref2),
    .p    (p)
  );

  assign sum = acc + {{N_LOG2{p[R]}}, p};

`ifdef SQ_DEMOD_ROUND_EN
  assign rnd = sum + (AW'(1) << (N_LOG2 - 1));
`else
  assign rnd = sum;
`endif

  assign shifted = rnd >>> N_LOG2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (in_valid) begin
        if (cnt == CNT_LAST) begin
          // Window closes on this sample; the next window starts on the following one.
          out       <= R'(sat_to_width(64'(shifted), R));
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
